// File: rtl/buffer0_pkg.sv
// Shared types and default geometry for the buffer0 read sequencer
// (Qn x KnT bridge buffer between linear projection and the systolic core).
package buffer0_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FILL,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned ROW_SIZE_MAT_C_B0 = 2;
    localparam int unsigned COL_SIZE_MAT_C_B0 = 2;
    localparam int unsigned MAX_FLAG_B0       = ROW_SIZE_MAT_C_B0 * COL_SIZE_MAT_C_B0;
    localparam int unsigned K_STEPS_B0        = 4;
    localparam int unsigned ADDR_WIDTH_W0_B0  = $clog2(ROW_SIZE_MAT_C_B0 * K_STEPS_B0);
    localparam int unsigned ADDR_WIDTH_N0_B0  = $clog2(COL_SIZE_MAT_C_B0 * K_STEPS_B0);
    localparam int unsigned FLAG_W_B0         = $clog2(MAX_FLAG_B0 + 1);

endpackage

// File: rtl/buffer0_sideband_pipe.sv
// Fixed-latency shift register that carries {valid, first, last, tile_idx}
// alongside the buffer read so sideband lines up with returned data.
module buffer0_sideband_pipe #(
    parameter int unsigned LAT = 1,
    parameter int unsigned W   = 4
)(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LAT); i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < int'(LAT); i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[LAT-1];

endmodule

// File: rtl/buffer0_read_ctrl.sv
// Paired west/north read sequencer for the buffer0 bridge; tags each beat with
// tile sideband. Optional stall counter under BUFFER0_CTRL_PERF_EN.
module buffer0_read_ctrl
    import buffer0_pkg::*;
#(
    parameter int unsigned ROW_TILES     = ROW_SIZE_MAT_C_B0,
    parameter int unsigned COL_TILES     = COL_SIZE_MAT_C_B0,
    parameter int unsigned K_STEPS       = K_STEPS_B0,
    parameter int unsigned ADDR_WIDTH_W0 = $clog2(ROW_TILES * K_STEPS),
    parameter int unsigned ADDR_WIDTH_N0 = $clog2(COL_TILES * K_STEPS),
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned FLAG_W        = $clog2(ROW_TILES * COL_TILES + 1)
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     w_fill_done,
    input  logic                     n_fill_done,
    input  logic                     out_ready,
    output logic                     en_w0,
    output logic [ADDR_WIDTH_W0-1:0] addr_w0,
    output logic                     en_n0,
    output logic [ADDR_WIDTH_N0-1:0] addr_n0,
    output logic                     beat_valid,
    output logic                     beat_first,
    output logic                     beat_last,
    output logic [FLAG_W-1:0]        tile_idx,
    output logic [FLAG_W-1:0]        flag_count,
    output logic                     busy,
`ifdef BUFFER0_CTRL_PERF_EN
    output logic [31:0]              stall_cycles,
`endif
    output logic                     done
);

    localparam int unsigned KW = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;
    localparam int unsigned CW = (COL_TILES > 1) ? $clog2(COL_TILES) : 1;
    localparam int unsigned RW = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1;
    localparam int unsigned DW = $clog2(RD_LATENCY + 1);
    localparam int unsigned SW = FLAG_W + 3;

    state_t            state, state_next;
    logic              issue;
    logic              w_ok, n_ok;
    logic [KW-1:0]     k;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DW-1:0]     drain_cnt;
    logic              first_q, last_q;
    logic [FLAG_W-1:0] tile_q;
    logic [SW-1:0]     sb_in, sb_out;
    logic              k_wrap, col_wrap, row_wrap;

    assign k_wrap   = (k == KW'(K_STEPS - 1));
    assign col_wrap = (col == CW'(COL_TILES - 1));
    assign row_wrap = (row == RW'(ROW_TILES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A fill pulse arriving in the same cycle counts as already filled.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE:      if (start) state_next = WAIT_FILL;
            WAIT_FILL: if ((w_ok || w_fill_done) && (n_ok || n_fill_done)) state_next = STREAM;
            STREAM: begin
                if (out_ready) begin
                    issue = 1'b1;
                    if (row_wrap && col_wrap && k_wrap) state_next = DRAIN;
                end
            end
            DRAIN:     if (drain_cnt == DW'(RD_LATENCY)) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_w0      <= 1'b0;
            en_n0      <= 1'b0;
            addr_w0    <= '0;
            addr_n0    <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            tile_q     <= '0;
            k          <= '0;
            col        <= '0;
            row        <= '0;
            flag_count <= '0;
            w_ok       <= 1'b0;
            n_ok       <= 1'b0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            en_w0     <= issue;
            en_n0     <= issue;
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);
            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;

            if (state_next == DONE) begin
                w_ok <= 1'b0;
                n_ok <= 1'b0;
            end else begin
                if (w_fill_done) w_ok <= 1'b1;
                if (n_fill_done) n_ok <= 1'b1;
            end

            if (state == IDLE && start) begin
                flag_count <= '0;
                k          <= '0;
                col        <= '0;
                row        <= '0;
            end

            // Inner dimension innermost, then output column, then output row.
            if (issue) begin
                addr_w0 <= ADDR_WIDTH_W0'(row * K_STEPS + k);
                addr_n0 <= ADDR_WIDTH_N0'(col * K_STEPS + k);
                first_q <= (k == '0);
                last_q  <= k_wrap;
                tile_q  <= FLAG_W'(row * COL_TILES + col);
                if (k_wrap) begin
                    k          <= '0;
                    flag_count <= flag_count + FLAG_W'(1);
                    if (col_wrap) begin
                        col <= '0;
                        row <= row_wrap ? '0 : row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end else begin
                    k <= k + KW'(1);
                end
            end
        end
    end

`ifdef BUFFER0_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (state == IDLE && start) begin
            stall_cycles <= '0;
        end else if (state == STREAM && !out_ready && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

    // Sideband is zeroed on idle cycles so it only ever describes a real beat.
    assign sb_in = {en_w0, en_w0 & first_q, en_w0 & last_q, en_w0 ? tile_q : FLAG_W'(0)};

    buffer0_sideband_pipe #(
        .LAT (RD_LATENCY),
        .W   (SW)
    ) u_sideband_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (sb_in),
        .dout (sb_out)
    );

    assign {beat_valid, beat_first, beat_last, tile_idx} = sb_out;

endmodule

// File: tb/tb_buffer0_read_ctrl.sv
// Scoreboard bench for buffer0_read_ctrl: default instance plus a RD_LATENCY=3
// instance sharing the same stimulus.
module tb_buffer0_read_ctrl;

    logic clk = 1'b0;
    logic rst, start, w_fill_done, n_fill_done, out_ready;

    logic       en_w0, en_n0, beat_valid, beat_first, beat_last, busy, done;
    logic [2:0] addr_w0, addr_n0, tile_idx, flag_count;
    logic       en_w3, en_n3, bv3, bf3, bl3, busy3, done3;
    logic [2:0] aw3, an3, tile3, flag3;
`ifdef BUFFER0_CTRL_PERF_EN
    logic [31:0] stall_cycles, stall3;
`endif

    always #5 clk = ~clk;

    buffer0_read_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .w_fill_done(w_fill_done),
        .n_fill_done(n_fill_done), .out_ready(out_ready),
        .en_w0(en_w0), .addr_w0(addr_w0), .en_n0(en_n0), .addr_n0(addr_n0),
        .beat_valid(beat_valid), .beat_first(beat_first), .beat_last(beat_last),
        .tile_idx(tile_idx), .flag_count(flag_count), .busy(busy),
`ifdef BUFFER0_CTRL_PERF_EN
        .stall_cycles(stall_cycles),
`endif
        .done(done)
    );

    buffer0_read_ctrl #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .w_fill_done(w_fill_done),
        .n_fill_done(n_fill_done), .out_ready(out_ready),
        .en_w0(en_w3), .addr_w0(aw3), .en_n0(en_n3), .addr_n0(an3),
        .beat_valid(bv3), .beat_first(bf3), .beat_last(bl3),
        .tile_idx(tile3), .flag_count(flag3), .busy(busy3),
`ifdef BUFFER0_CTRL_PERF_EN
        .stall_cycles(stall3),
`endif
        .done(done3)
    );

    typedef struct {
        int aw;
        int an;
        bit first;
        bit last;
        int tile;
    } exp_t;

    exp_t iss_q[$];
    exp_t beat_q[$];
    int   aw_tab [16] = '{0,1,2,3, 0,1,2,3, 4,5,6,7, 4,5,6,7};
    int   an_tab [16] = '{0,1,2,3, 4,5,6,7, 0,1,2,3, 4,5,6,7};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int beats    = 0;
    int issues   = 0;
    int beats3   = 0;
    int first_en_cyc  = -1;
    int last_beat_cyc = 0;
    int last_beat3    = 0;
    logic [2:0] hist3 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expected issues/beats whenever the DUTs present them.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            beats  = 0;
            issues = 0;
            beats3 = 0;
            hist3  = '0;
        end else begin
            if (en_w0 || en_n0) begin
                check("en_pair", en_n0, en_w0);
                if (iss_q.size() == 0) fail_now("unexpected_issue");
                else begin
                    e = iss_q.pop_front();
                    check("addr_w0", addr_w0, e.aw);
                    check("addr_n0", addr_n0, e.an);
                end
                if (issues == 0) first_en_cyc = cyc;
                issues++;
            end
            if (beat_valid) begin
                if (beat_q.size() == 0) fail_now("unexpected_beat");
                else begin
                    e = beat_q.pop_front();
                    check("beat_first", beat_first, e.first);
                    check("beat_last", beat_last, e.last);
                    check("tile_idx", tile_idx, e.tile);
                end
                beats++;
                last_beat_cyc = cyc;
            end
            if (done) begin
                check("done_gap", cyc - last_beat_cyc, 1);
                check("flag_count_done", flag_count, 4);
                check("beats_per_pass", beats, 16);
                beats  = 0;
                issues = 0;
            end
            // Latency-3 instance: beat_valid must be en exactly three cycles late.
            if (hist3[2] || bv3) check("lat3_valid", bv3, hist3[2]);
            hist3 = {hist3[1:0], en_w3};
            if (bv3) begin
                beats3++;
                last_beat3 = cyc;
            end
            if (done3) begin
                check("lat3_done_gap", cyc - last_beat3, 1);
                check("lat3_flag_count", flag3, 4);
                check("lat3_beats", beats3, 16);
                beats3 = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.aw    = aw_tab[i];
            e.an    = an_tab[i];
            e.first = (i % 4 == 0);
            e.last  = (i % 4 == 3);
            e.tile  = i / 4;
            iss_q.push_back(e);
            beat_q.push_back(e);
        end
    endtask

    task automatic pulse_fills(input bit w, input bit n);
        w_fill_done = w;
        n_fill_done = n;
        step();
        w_fill_done = 1'b0;
        n_fill_done = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit toggle, input bit inject);
        int n = 0;
        while ((busy || busy3) && n < 400) begin
            if (toggle) out_ready = ~out_ready;
            start       = inject && (n == 6);
            w_fill_done = inject && (n == 9);
            step();
            n++;
        end
        out_ready   = 1'b1;
        start       = 1'b0;
        w_fill_done = 1'b0;
        check("pass_timeout", (n >= 400), 0);
        step();
        check("queues_drained", iss_q.size() + beat_q.size(), 0);
        check("idle_after_done", {busy, done, busy3, done3}, 0);
        check("flag_count_hold", flag_count, 4);
    endtask

    initial begin
        int  t0, n;
        bit  bad, seen;

        rst = 1'b1; start = 1'b0; w_fill_done = 1'b0; n_fill_done = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("reset_outputs", {en_w0, addr_w0, en_n0, addr_n0, beat_valid, beat_first,
                                beat_last, tile_idx, flag_count, busy, done, bv3, done3}, 0);
        step();
        rst = 1'b0;
        step();

        // Basic pass: fills, then start, continuous ready.
        push_expected();
        pulse_fills(1'b1, 1'b1);
        pulse_start();
        check("busy_after_start", busy, 1);
        wait_done(1'b0, 1'b0);

        // Start without fills: no issue for 20 cycles, then abort by reset.
        pulse_start();
        bad = 1'b0;
        repeat (20) begin
            step();
            if (en_w0 || en_n0 || !busy) bad = 1'b1;
        end
        check("wait_fill_hold", bad, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Fills at start+5 and start+12: en presented after edge start+13,
        // captured by the buffer at edge start+14.
        push_expected();
        pulse_start();
        t0 = cyc;
        repeat (4) step();
        pulse_fills(1'b1, 1'b0);
        repeat (6) step();
        pulse_fills(1'b0, 1'b1);
        wait_done(1'b0, 1'b0);
        check("first_issue_cycle", first_en_cyc - t0, 13);

        // out_ready toggling every cycle: same sequence, nothing lost.
        push_expected();
        pulse_fills(1'b1, 1'b1);
        pulse_start();
        wait_done(1'b1, 1'b0);
`ifdef BUFFER0_CTRL_PERF_EN
        check("stall_cycles", (stall_cycles == 15 || stall_cycles == 16), 1);
`endif

        // Reset after the 7th beat aborts the pass with no done.
        push_expected();
        pulse_fills(1'b1, 1'b1);
        pulse_start();
        n = 0;
        while (beats < 7 && n < 100) begin
            step();
            n++;
        end
        check("abort_reached_beat7", (n < 100), 1);
        rst = 1'b1;
        step();
        @(negedge clk);
        check("abort_outputs", {en_w0, addr_w0, en_n0, addr_n0, beat_valid, beat_first,
                                beat_last, tile_idx, flag_count, busy, done, bv3, busy3}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        iss_q.delete();
        beat_q.delete();
        seen = 1'b0;
        repeat (10) begin
            step();
            if (done || done3) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);

        // Fresh pass after abort restarts from address 0.
        push_expected();
        pulse_fills(1'b1, 1'b1);
        pulse_start();
        wait_done(1'b0, 1'b0);

        // Stray start and w_fill_done during STREAM change nothing.
        push_expected();
        pulse_fills(1'b1, 1'b1);
        pulse_start();
        wait_done(1'b0, 1'b1);

        // The stray west fill was cleared entering DONE: north alone must not release.
        push_expected();
        pulse_fills(1'b0, 1'b1);
        pulse_start();
        bad = 1'b0;
        repeat (10) begin
            step();
            if (en_w0 || en_n0) bad = 1'b1;
        end
        check("stale_w_ok_cleared", bad, 0);
        pulse_fills(1'b1, 1'b0);
        wait_done(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
